// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//   Time-multiplexes one external 8-bit ALU over WIDTH/8 byte slices, LSB first, chaining the
//   slice carry. After the last slice it derives the flags and the number of leading 7-segment
//   digits to blank, pulses OUT_done and raises the result-ready tone request. While idle it
//   passes the operand being typed through to the display.
//
//   Optional feature macro: CORE_SIGNED_DISP_EN
//     defined     : sub/cmp results show their two's-complement magnitude, OUT_neg_ans active
//     not defined : OUT_neg_ans tied 0, blanking computed on the raw unsigned result
//
// Ports
//   IN_clk, IN_rst          clock, synchronous active-high reset
//   IN_finish               '=' key, starts an operation from IDLE
//   IN_ALU_OP               A add, B sub, C and, D or, E cmp
//   IN_SRC, IN_DST          operands (WIDTH bits)
//   IN_state, IN_flag       keypad state and digit count of the current number
//   IN_S, IN_carry_in       ALU slice result and carry/no-borrow
//   IN_music_on             sound block ack; low clears OUT_music_on
//   OUT_data_a/b, OUT_ALU_OP, OUT_alu_cin   ALU slice operands, opcode, carry-in
//   OUT_value, OUT_off_number               display value and leading digits to blank
//   OUT_carry_out, OUT_neg_ans, OUT_less_than, OUT_zero   result flags
//   OUT_music_on, OUT_busy, OUT_done, state              status
module alu_slice_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned FLAG_W = 2
) (
    input  logic                         IN_clk,
    input  logic                         IN_rst,
    input  logic                         IN_finish,
    input  logic [3:0]                   IN_ALU_OP,
    input  logic [WIDTH-1:0]             IN_SRC,
    input  logic [WIDTH-1:0]             IN_DST,
    input  logic [1:0]                   IN_state,
    input  logic [FLAG_W-1:0]            IN_flag,
    input  logic [7:0]                   IN_S,
    input  logic                         IN_carry_in,
    input  logic                         IN_music_on,
    output logic [7:0]                   OUT_data_a,
    output logic [7:0]                   OUT_data_b,
    output logic [3:0]                   OUT_ALU_OP,
    output logic                         OUT_alu_cin,
    output logic [WIDTH-1:0]             OUT_value,
    output logic [$clog2(DIGITS+1)-1:0]  OUT_off_number,
    output logic                         OUT_carry_out,
    output logic                         OUT_neg_ans,
    output logic                         OUT_less_than,
    output logic                         OUT_zero,
    output logic                         OUT_music_on,
    output logic                         OUT_busy,
    output logic                         OUT_done,
    output logic [1:0]                   state
);

    localparam int unsigned SLICES = WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(DIGITS + 1);
    localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    // Decimal digit thresholds are compared at least 64 bits wide so 10**i never truncates
    localparam int unsigned CW     = (WIDTH > 64) ? WIDTH : 64;

    localparam logic [3:0] OpAdd = 4'hA;
    localparam logic [3:0] OpSub = 4'hB;
    localparam logic [3:0] OpAnd = 4'hC;
    localparam logic [3:0] OpOr  = 4'hD;
    localparam logic [3:0] OpCmp = 4'hE;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFinal = 2'd2,
        StHold  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
    logic [3:0]         op_q, op_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   value_q, value_d, mag;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               cout_q, cout_d, neg_q, neg_d, lt_q, lt_d, zero_q, zero_d;
    logic               music_q, music_d, done_q, done_d;
    logic               logic_op;

    // Leading digits to blank for a value: at least one digit is always shown
    function automatic logic [OFF_W-1:0] blank_count(input logic [WIDTH-1:0] v);
        logic [CW-1:0] m;
        logic [CW-1:0] p;
        int            sig;
        m   = CW'(v);
        p   = CW'(10);
        sig = 1;
        for (int i = 1; i < int'(DIGITS); i++) begin
            if (m >= p) sig = i + 1;
            p = p * CW'(10);
        end
        return OFF_W'(int'(DIGITS) - sig);
    endfunction

    // Blanking while typing, floored at zero
    function automatic logic [OFF_W-1:0] typed_blank(input logic [FLAG_W-1:0] flag);
        if (int'(flag) >= int'(DIGITS)) return '0;
        return OFF_W'(int'(DIGITS) - int'(flag));
    endfunction

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            value_q <= '0;
            off_q   <= OFF_W'(DIGITS);
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            lt_q    <= 1'b0;
            zero_q  <= 1'b0;
            music_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            value_q <= value_d;
            off_q   <= off_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            lt_q    <= lt_d;
            zero_q  <= zero_d;
            music_q <= music_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        value_d  = value_q;
        off_d    = off_q;
        cout_d   = cout_q;
        neg_d    = neg_q;
        lt_d     = lt_q;
        zero_d   = zero_q;
        music_d  = music_q;
        done_d   = 1'b0;
        idx_nxt  = idx_q + 1'b1;
        mag      = value_q;
        logic_op = (op_q == OpAnd) || (op_q == OpOr);

        case (state_q)
            StIdle: begin
                a_d     = '0;
                b_d     = '0;
                cin_d   = 1'b0;
                op_d    = '0;
                cout_d  = 1'b0;
                neg_d   = 1'b0;
                lt_d    = 1'b0;
                zero_d  = 1'b0;
                music_d = 1'b0;
                if (IN_finish && (IN_ALU_OP inside {OpAdd, OpSub, OpAnd, OpOr, OpCmp})) begin
                    src_d   = IN_SRC;
                    dst_d   = IN_DST;
                    op_d    = IN_ALU_OP;
                    a_d     = IN_SRC[7:0];
                    b_d     = IN_DST[7:0];
                    // Subtraction runs as a + ~b + 1, so the first slice gets carry-in 1
                    cin_d   = (IN_ALU_OP == OpSub) || (IN_ALU_OP == OpCmp);
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    case (IN_state)
                        2'd0: off_d = OFF_W'(DIGITS);
                        2'd1: begin
                            value_d = IN_SRC;
                            off_d   = typed_blank(IN_flag);
                        end
                        2'd2: ;
                        2'd3: begin
                            value_d = IN_DST;
                            off_d   = typed_blank(IN_flag);
                        end
                    endcase
                end
            end

            StRun: begin
                value_d[int'(idx_q)*8 +: 8] = IN_S;
                carry_d = IN_carry_in;
                cin_d   = logic_op ? 1'b0 : IN_carry_in;
                if (idx_q == IDX_W'(SLICES - 1)) begin
                    state_d = StFinal;
                end else begin
                    idx_d = idx_nxt;
                    a_d   = 8'(src_q >> (8 * idx_nxt));
                    b_d   = 8'(dst_q >> (8 * idx_nxt));
                end
            end

            StFinal: begin
                cout_d = logic_op ? 1'b0 : carry_q;
                lt_d   = (op_q == OpCmp) && !carry_q;
                zero_d = (value_q == '0);
`ifdef CORE_SIGNED_DISP_EN
                neg_d  = ((op_q == OpSub) || (op_q == OpCmp)) && value_q[WIDTH-1];
                if (neg_d) mag = ~value_q + 1'b1;
`else
                neg_d  = 1'b0;
`endif
                off_d   = blank_count(mag);
                done_d  = 1'b1;
                music_d = 1'b1;
                state_d = StHold;
            end

            StHold: begin
                if (!IN_music_on) music_d = 1'b0;
                // Any keypad activity or the clear key leaves the result screen
                if ((IN_state != 2'd0) || (&IN_flag)) begin
                    state_d = StIdle;
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = 1'b0;
                    op_d    = '0;
                    cout_d  = 1'b0;
                    neg_d   = 1'b0;
                    lt_d    = 1'b0;
                    zero_d  = 1'b0;
                    music_d = 1'b0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign OUT_data_a     = a_q;
    assign OUT_data_b     = b_q;
    assign OUT_ALU_OP     = op_q;
    assign OUT_alu_cin    = cin_q;
    assign OUT_value      = value_q;
    assign OUT_off_number = off_q;
    assign OUT_carry_out  = cout_q;
    assign OUT_neg_ans    = neg_q;
    assign OUT_less_than  = lt_q;
    assign OUT_zero       = zero_q;
    assign OUT_music_on   = music_q;
    assign OUT_busy       = (state_q == StRun);
    assign OUT_done       = done_q;
    assign state          = state_q;

endmodule
